// File: rtl/mac_row_simd.sv
// Weight-stationary systolic MAC row: col PEs chained west to east, each holding
// one (or two, in SIMD mode) signed weights, with psum saturation, row stall and weight clear.
module mac_row_simd #(
    parameter int unsigned bw      = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned sat     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode_2b,
    input  logic                   stall,
    input  logic                   wclr,
    input  logic [bw-1:0]          in_w,
    input  logic [1:0]             inst_w,
    input  logic [psum_bw*col-1:0] in_n,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid
);
    localparam int unsigned HB = bw / 2;
    localparam logic signed [psum_bw:0] SMAX = {2'b00, {(psum_bw-1){1'b1}}};
    localparam logic signed [psum_bw:0] SMIN = {2'b11, {(psum_bw-1){1'b0}}};

    logic        [bw-1:0]      a_q    [col];
    logic        [bw-1:0]      a_d    [col];
    logic signed [bw-1:0]      w0_q   [col];
    logic signed [bw-1:0]      w0_d   [col];
    logic signed [bw-1:0]      w1_q   [col];
    logic signed [bw-1:0]      w1_d   [col];
    logic        [1:0]         cnt_q  [col];
    logic        [1:0]         cnt_d  [col];
    logic        [1:0]         inst_q [col];
    logic        [1:0]         inst_d [col];
    logic        [psum_bw-1:0] ps_q   [col];
    logic        [psum_bw-1:0] ps_d   [col];

    logic        [bw-1:0]      a_in    [col];
    logic        [1:0]         inst_in [col];
    logic        [1:0]         need;

    // Operands are widened to psum_bw+1 bits before multiplying; the exact
    // products fit as long as psum_bw+1 >= 2*bw+2.
    function automatic logic [psum_bw-1:0] mac(
        input logic        [bw-1:0]      a,
        input logic signed [bw-1:0]      w0,
        input logic signed [bw-1:0]      w1,
        input logic                      m,
        input logic        [psum_bw-1:0] north
    );
        logic signed [psum_bw:0] prod;
        logic signed [psum_bw:0] sum;
        if (m)
            prod = $signed((psum_bw+1)'(a[HB-1:0])) * (psum_bw+1)'(w0)
                 + $signed((psum_bw+1)'(a[bw-1:HB])) * (psum_bw+1)'(w1);
        else
            prod = $signed((psum_bw+1)'(a)) * (psum_bw+1)'(w0);
        sum = (psum_bw+1)'($signed(north)) + prod;
        if (sat != 0) begin
            if (sum > SMAX)
                sum = SMAX;
            else if (sum < SMIN)
                sum = SMIN;
        end
        return sum[psum_bw-1:0];
    endfunction

    assign need = mode_2b ? 2'd2 : 2'd1;

    always_comb begin
        a_in[0]    = in_w;
        inst_in[0] = inst_w;
        for (int unsigned i = 1; i < col; i++) begin
            a_in[i]    = a_q[i-1];
            inst_in[i] = inst_q[i-1];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < col; i++) begin
            logic loaded;
            loaded    = (cnt_q[i] >= need);
            a_d[i]    = a_q[i];
            w0_d[i]   = w0_q[i];
            w1_d[i]   = w1_q[i];
            cnt_d[i]  = cnt_q[i];
            inst_d[i] = inst_q[i];
            ps_d[i]   = ps_q[i];
            if (!stall) begin
                // A load token is consumed by the first PE still short of weights.
                if (inst_in[i][0] && !loaded) begin
                    if (cnt_q[i] == 2'd0)
                        w0_d[i] = a_in[i];
                    else
                        w1_d[i] = a_in[i];
                    cnt_d[i] = cnt_q[i] + 2'd1;
                end
                inst_d[i] = {inst_in[i][1], inst_in[i][0] & loaded};
                if (inst_in[i][1] || (inst_in[i][0] && loaded))
                    a_d[i] = a_in[i];
                if (inst_in[i][1])
                    ps_d[i] = mac(a_in[i], w0_q[i], w1_q[i], mode_2b,
                                  in_n[i*psum_bw +: psum_bw]);
            end
            // Weight clear overrides both the load path and the stall hold.
            if (wclr) begin
                w0_d[i]      = '0;
                w1_d[i]      = '0;
                cnt_d[i]     = '0;
                inst_d[i][0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < col; i++) begin
                a_q[i]    <= '0;
                w0_q[i]   <= '0;
                w1_q[i]   <= '0;
                cnt_q[i]  <= '0;
                inst_q[i] <= '0;
                ps_q[i]   <= '0;
            end
        end else begin
            a_q    <= a_d;
            w0_q   <= w0_d;
            w1_q   <= w1_d;
            cnt_q  <= cnt_d;
            inst_q <= inst_d;
            ps_q   <= ps_d;
        end
    end

    always_comb begin
        out_s = '0;
        valid = '0;
        for (int unsigned i = 0; i < col; i++) begin
            out_s[i*psum_bw +: psum_bw] = ps_q[i];
            valid[i]                    = inst_q[i][1];
        end
    end

endmodule

// File: doc/mac_row_simd.md
# mac_row_simd

Parametrised, self-contained systolic MAC row: `col` processing elements (PEs) in a west-to-east chain, weight-stationary. Activations and instruction tokens ripple east one PE per cycle; partial sums flow north-to-south through each PE. Over the previous row generation it adds:
- a 2-bit SIMD mode in which each PE holds two weights;
- optional psum saturation;
- a row-wide stall;
- a synchronous weight clear.

It sits between the activation/instruction feeder and the next row, or the output FIFO, of the array.

## Interface
- `bw`, 4: activation/weight width; must be even.
- `psum_bw`, 16: partial-sum width, two's complement.
- `col`, 8: number of PEs.
- `sat`, 0: 1 clamps psums to the signed `psum_bw` range; 0 wraps modulo 2^psum_bw.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `mode_2b` in 1: 0 = bw x bw mode; 1 = SIMD mode, two bw/2-bit activation lanes.
- `stall` in 1: 1 holds all state, except as stated under `wclr`.
- `wclr` in 1: synchronous clear of all weights and load counts.
- `in_w` in bw: activation/weight data into PE0.
- `inst_w` in 2: [1] execute, [0] kernel load; into PE0.
- `in_n` in psum_bw*col: psum from north; PE i uses slice [i*psum_bw +: psum_bw].
- `out_s` out psum_bw*col: registered psum to south, same slicing.
- `valid` out col: valid[i] marks out_s slice i as valid.

## Operation
- Per-PE state:
  - `a_q` (bw)
  - `w0_q`, `w1_q` (bw, signed)
  - `cnt_q` (2b)
  - `inst_q` (2b)
  - `ps_q` (psum_bw)
- PE i inputs: PE0 takes a_in=`in_w`, inst_in=`inst_w`; PE i>0 takes `a_q`/`inst_q` of PE i-1.
- need = 1 when mode_2b=0, else 2. loaded = (cnt_q >= need), evaluated on current state.
- Weight capture: inst_in[0]=1 and not loaded.
  - cnt_q=0 loads w0_q <= a_in; cnt_q=1 loads w1_q <= a_in.
  - cnt_q increments, saturating at 2.
  - The token is consumed: it is not passed east.
- Token pass: inst_q[0] <= inst_in[0] & loaded. inst_q[1] <= inst_in[1].
- Activation: a_q <= a_in when inst_in[1] | (inst_in[0] & loaded); otherwise a_q holds.
- Execute: when inst_in[1]=1, ps_q <= in_n slice + P. When inst_in[1]=0, ps_q holds.
- Product P, with activations unsigned and weights signed:
  - mode 0: P = a_in * w0_q.
  - mode 1: P = a_in[bw/2-1:0]*w0_q + a_in[bw-1:bw/2]*w1_q.
- Width rules: P is sign-extended to psum_bw+1 bits before the add.
  - sat=1: results above 2^(psum_bw-1)-1 clamp to that value; results below -2^(psum_bw-1) clamp to that value.
  - sat=0: the result is truncated to psum_bw bits.
- Outputs: out_s slice i = ps_q(i); valid[i] = inst_q[1] of PE i.
- Mode switch does not clear weights.
  - 1→0 with cnt_q=2: PE is loaded and uses w0_q only.
  - 0→1 with cnt_q=1: PE is not loaded; the next token fills w1_q.
- `stall`=1: no register changes, except as stated under `wclr`. Outputs hold their values.
- `wclr`=1:
  - w0_q, w1_q, cnt_q <= 0 in all PEs.
  - The inst_q[0] token is discarded: inst_q[0] <= 0.
  - Applies regardless of `stall`.
  - All other registers follow the normal/stall rules.
- Reset low, at any time including mid-load or mid-execute:
  - every register goes to 0;
  - out_s=0 and valid=0 while low;
  - the first update occurs on the first rising edge after release.

## Timing
- Token/activation reach PE i i cycles after entering PE0, stalls excluded.
- Execute token presented at PE0 in cycle t: out_s slice i and valid[i] are updated at edge t+i+1 and remain until the next update.
- Full load needs col*need tokens. The last weight reaches PE col-1 after the (col*need)-th token plus col-1 cycles.
- Extra tokens beyond a full load exit east of PE col-1 and are dropped.
- Each stall cycle delays all subsequent timing by exactly one cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset: drive reset=0 mid-execute with random inputs → out_s=0 and valid=0 immediately. After release with inst_w=0 → outputs stay 0.
- Mode 0 load, defaults: 8 tokens in_w=1..8 → PE i holds w0=i+1. Execute a=3, in_n=0 → out_s[i]=3(i+1) and valid[i] at t+i+1. Then w0=-1 (4'hF), a=15, in_n=100 → 85.
- SIMD: mode_2b=1, 16 tokens alternating 3 and -2 (4'hE) → every PE has w0=3, w1=-2. Execute a=4'b1001, in_n=10 → out_s=9 (1*3 + 2*(-2) + 10) in every slice.
- Saturation: w0=7, a=15, in_n=32767. sat=1 → 32767; sat=0 → -32664. in_n=-32768 with w0=-8 → sat=1 gives -32768.
- Stall: 3-cycle stall inserted during an execute stream → out_s/valid frozen for those cycles; the post-stall sequence is identical to the unstalled run, shifted by 3 cycles.
- wclr with a load token and stall=1 in the same cycle → all weights/counts 0 and the token gone. A following execute with in_n=5 → out_s=5 in every slice.
